nibble_serial_addsub: RTL

- Multi-cycle sequencer for signed add/subtract of W = 4*NIBBLES-bit operands, one 4-bit slice per clock.
- Reuses the team's 4-bit two's-complement add/sub slice as its datapath. The carry is registered between slices.
- Sits upstream of the register-file write-back path. Gives wide arithmetic at the area cost of a single 4-bit adder.

---
 rtl/nibble_serial_addsub.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle signed add/subtract of W = 4*NIBBLES bits using one 4-bit slice per clock.
// Optional macro NIBBLE_SERIAL_ADDSUB_SAT_EN saturates the result on signed overflow.
module nibble_serial_addsub #(
  parameter int unsigned  NIBBLES = 4,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned LSB_W = IDX_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_sub;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_overflow;

  logic [LSB_W-1:0]   w_lsb;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [4:0]         w_sum;
  logic               w_c3;
  logic               w_ov;

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  // Shared 4-bit two's-complement add/sub slice selected by the slice index
  assign w_lsb   = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_lsb +: 4];
  assign w_b_nib = r_b[w_lsb +: 4] ^ {4{r_sub}};
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  // Carry into bit 3 recovered from the bit-3 sum and its two inputs
  assign w_c3    = w_sum[3] ^ w_a_nib[3] ^ w_b_nib[3];
  assign w_ov    = w_c3 ^ w_sum[4];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sub   <= sub;
        r_carry <= sub;
        r_idx   <= '0;
      end else if (r_state == S_RUN) begin
        r_result[w_lsb +: 4] <= w_sum[3:0];
        r_carry              <= w_sum[4];
        r_idx                <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_cout     <= w_sum[4];
          r_overflow <= w_ov;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
          // Whole-word clamp overrides the final slice write; flags stay raw
          if (w_ov) begin
            r_result <= w_a_nib[3] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`endif
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign zero     = (r_result == '0);

endmodule
